mult_unit: RTL and testbench
============================

Name: mult_unit

Overview:
Iterative shift-add multiplier for MULT/MULTU in the EX stage. It sits beside the 32-bit ALU built from the per-bit ALU slices and owns the HI/LO architectural registers. It also serves MTHI/MTLO writes and drives a busy stall back to the hazard unit. Each multiply takes a fixed 33 cycles from start to result.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
start  in  1  begin a multiply; sampled only in IDLE
is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
a  in  WIDTH  multiplicand (rs); sampled with start
b  in  WIDTH  multiplier (rt); sampled with start
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  multiply in progress; the pipeline stalls MFHI/MFLO/MULT while it is high
done  out  1  one-cycle pulse when HI/LO take a new product
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: rst_n=0 at a rising edge sets state=IDLE, count=0, busy=0, done=0, hi=0, lo=0. Reset wins over every other input. Reset mid-multiply abandons the operation and produces no done pulse.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch mcand=|a| and mplier=|b| (magnitudes only when is_signed=1).
  - Latch neg = is_signed & (a[W-1]^b[W-1]).
  - Clear acc (WIDTH+1 bits) and count; go to RUN; busy=1 from E0.
  - |0x80000000| is 0x80000000, treated as unsigned.
- RUN, one step per edge, for 32 edges (E1..E32):
  - If mplier[0]=1, sum = acc + mcand (WIDTH+1 bits); otherwise sum = acc.
  - Shift the {sum, mplier} concatenation right by 1.
  - Increment count; after the step with count=WIDTH-1, go to FIX.
- FIX, edge E33:
  - product = {acc[W-1:0], mplier}.
  - If neg=1, product = ~product + 1 (64-bit).
  - hi=product[63:32], lo=product[31:0].
  - done=1 for the cycle after E33; busy=0 from E33; go to IDLE.
- Latency: done is visible 33 cycles after start was sampled. Back-to-back start is accepted in the done cycle.
- start while busy (RUN or FIX) is ignored; the latched operands do not change.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; the write lands at that edge.
  - Dropped while busy.
  - If they coincide with start in IDLE, start wins and the writes are dropped.
  - hi_we and lo_we together write wdata to both registers.
- hi/lo hold their values throughout RUN and change only at FIX, reset, or an MT write.
- done is 0 in every cycle other than the one after FIX.

Decomposition:
- Shared package (mips_pkg):
  - state encoding: IDLE=2'd0, RUN=2'd1, FIX=2'd2.
  - WIDTH default.
  - function abs_w(value, signed_flag).
- One combinational sub-module, mult_step. Inputs: acc, mcand, mplier. Outputs: next acc and next mplier for one add-shift step. The FSM, counter and HI/LO registers stay in mult_unit.

Test Plan:
- MULTU a=7, b=6 -> busy=1 for 33 cycles; done pulses at cycle 33; hi=0x00000000, lo=0x0000002A.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT with the same operands -> hi=0, lo=1.
- MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Boundary for the most-negative value.
- Check the following sequence:
  - Start a multiply; assert start with new operands and hi_we=1 at cycle 10 -> both ignored; the result matches the first operands.
  - In IDLE, lo_we=1 with wdata=0x1234 -> lo=0x1234 at the next edge; hi is unchanged.
- Start MULTU 3*4; drive rst_n=0 at cycle 12 -> the next cycle shows busy=0, hi=lo=0, state IDLE; no done pulse follows; a new start then completes normally with lo=12.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, multiplier state encoding and magnitude helper
//
// Purpose: definitions shared by the multiplier files.
// Contents:
//   DEFAULT_WIDTH  datapath width used by mult_unit and mult_step
//   state_t        multiplier FSM encoding (IDLE, RUN, FIX)
//   abs_w()        magnitude of a value, taken only when signed_flag is set
package mips_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // The most-negative value maps onto itself, which is the correct
  // magnitude once it is read as unsigned.
  function automatic logic [DEFAULT_WIDTH-1:0] abs_w(
    input logic [DEFAULT_WIDTH-1:0] value,
    input logic                     signed_flag
  );
    if (signed_flag && value[DEFAULT_WIDTH-1]) begin
      return (~value) + {{(DEFAULT_WIDTH-1){1'b0}}, 1'b1};
    end
    return value;
  endfunction

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one add-shift step of the iterative multiplier
//
// Purpose: combinational add-then-shift step.
// Ports:
//   acc         in   WIDTH+1  partial-product accumulator
//   mcand       in   WIDTH    multiplicand magnitude
//   mplier      in   WIDTH    remaining multiplier bits (low half of product)
//   acc_next    out  WIDTH+1  accumulator after this step
//   mplier_next out  WIDTH    multiplier after this step
module mult_step import mips_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] mplier_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    if (mplier[0]) begin
      sum = acc + {1'b0, mcand};
    end
    // The bit shifted out of the sum becomes the next product bit,
    // filling the multiplier register from the top.
    {acc_next, mplier_next} = {sum, mplier} >> 1;
  end

endmodule

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative shift-add MULT/MULTU unit owning HI/LO
//
// Purpose: 33-cycle multiplier with HI/LO registers and MTHI/MTLO writes.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, is_signed     begin a multiply (IDLE only), signed select
//   a, b                 operands, sampled with start
//   hi_we, lo_we, wdata  MTHI/MTLO writes, honoured in IDLE without start
//   busy                 multiply in progress
//   done                 one-cycle pulse when HI/LO take a new product
//   hi, lo               architectural HI/LO registers
module mult_unit import mips_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH:0]     acc, acc_next;
  logic [WIDTH-1:0]   mcand, mplier, mplier_next;
  logic               neg;
  logic [2*WIDTH-1:0] raw_product, product;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_next),
    .mplier_next (mplier_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (count == LAST_STEP) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Magnitudes are multiplied; the sign is restored in FIX.
  always_comb begin
    raw_product = {acc[WIDTH-1:0], mplier};
    product     = raw_product;
    if (neg) begin
      product = (~raw_product) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= abs_w(a, is_signed);
            mplier <= abs_w(b, is_signed);
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          count  <= count + CNT_W'(1);
        end
        FIX: begin
          hi   <= product[2*WIDTH-1:WIDTH];
          lo   <= product[WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// tb/tb_mult_unit.sv - self-checking bench for mult_unit
module tb_mult_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, is_signed, hi_we, lo_we;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] sb[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  // Drives start through edge E0 and returns #1 after it.
  task automatic start_mult(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1'b1;
    sb.push_back(model(x, y, s));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_at_e0", 64'(busy), 64'd1);
    check("done_low_at_e0", 64'(done), 64'd0);
  endtask

  // Waits for done; optionally injects an ignored start+hi_we at cycle inject_at.
  task automatic wait_done(input string tag, input int inject_at);
    int lat = 0;
    int busy_cycles = 1;
    logic [63:0] exp;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == inject_at) begin
        start = 1'b1; is_signed = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0;
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) busy_cycles++;
      if (cyc < 33) check({tag, "_hi_hold"}, 64'(hi), 64'(model_hi));
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
    if (lat == 0) return;
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
    check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    exp = sb.pop_front();
    check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    model_hi = exp[63:32];
    model_lo = exp[31:0];
  endtask

  initial begin
    int seen_done;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    start_mult(32'd7, 32'd6, 1'b0);                       wait_done("multu_7x6", 0);
    check("lo_42", 64'(lo), 64'h2A);
    start_mult(32'hFFFF_FFFD, 32'd5, 1'b1);               wait_done("mult_m3x5", 0);
    start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);       wait_done("multu_max", 0);
    start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);       wait_done("mult_m1", 0);
    start_mult(32'h8000_0000, 32'h8000_0000, 1'b1);       wait_done("mult_minneg", 0);
    start_mult(32'h8000_0000, 32'h0000_0003, 1'b1);       wait_done("mult_minneg_x3", 0);
    start_mult(32'h0000_1111, 32'h0000_0010, 1'b0);       wait_done("ignore_start", 10);

    @(negedge clk); lo_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1; lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_hi_kept", 64'(hi), 64'(model_hi));
    @(negedge clk); hi_we = 1'b1; wdata = 32'h0000_ABCD;
    @(posedge clk); #1; hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'hABCD);
    check("mthi_lo_kept", 64'(lo), 64'h1234);
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    check("mtboth_hi", 64'(hi), 64'h5555_AAAA);
    check("mtboth_lo", 64'(lo), 64'h5555_AAAA);
    model_hi = 32'h5555_AAAA;

    start_mult(32'd3, 32'd4, 1'b0);
    repeat (11) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hi", 64'(hi), 64'd0);
    check("rstmid_lo", 64'(lo), 64'd0);
    check("rstmid_state", 64'(dut.state), 64'(IDLE));
    void'(sb.pop_front());
    model_hi = '0; model_lo = '0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("rstmid_no_done", 64'(seen_done), 64'd0);
    start_mult(32'd3, 32'd4, 1'b0);                       wait_done("after_rst", 0);
    check("after_rst_lo_12", 64'(lo), 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
